// File: rtl/control_step_sequencer.sv
// Fetch/decode/execute step sequencer with registered Moore strobes, memory-wait timeout and retired-instruction counter.
// Outputs change one edge after the state decision; Run only gates starting a new fetch, MemDone paces T1.
module control_step_sequencer #(
  parameter int OPC_MSB     = 31,
  parameter int OPC_BITS    = 5,
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Run,
  input  logic             MemDone,
  input  logic [31:0]      IR,
  output logic             PCout,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             MDRout,
  output logic             MARin,
  output logic             Zin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             IncPC,
  output logic             Read,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             LOin,
  output logic             HIin,
  output logic [2:0]       ALU_op,
  output logic [2:0]       Step,
  output logic             Illegal,
  output logic             Fault,
  output logic [CNT_W-1:0] Retired
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
  localparam logic [2:0] S_T5   = 3'd6;
  localparam logic [2:0] S_T6   = 3'd7;

  localparam logic [OPC_BITS-1:0] OP_ADD = OPC_BITS'(3);
  localparam logic [OPC_BITS-1:0] OP_SUB = OPC_BITS'(4);
  localparam logic [OPC_BITS-1:0] OP_AND = OPC_BITS'(5);
  localparam logic [OPC_BITS-1:0] OP_OR  = OPC_BITS'(6);
  localparam logic [OPC_BITS-1:0] OP_MUL = OPC_BITS'(15);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef struct packed {
    logic       pc_out;
    logic       zlow_out;
    logic       zhigh_out;
    logic       mdr_out;
    logic       mar_in;
    logic       z_in;
    logic       pc_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       inc_pc;
    logic       read;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       lo_in;
    logic       hi_in;
    logic [2:0] alu_op;
    logic       illegal;
  } ctl_t;

  logic [2:0]          state, state_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_n;
  logic [OPC_BITS-1:0] opc, opc_n;
  logic                fault_n;
  logic                retire;
  ctl_t                ctl, ctl_n;
  logic                unused_ir;

  assign unused_ir = ^IR;

  // Zero ALU code doubles as the "illegal opcode" marker.
  function automatic logic [2:0] alu_of(input logic [OPC_BITS-1:0] op);
    case (op)
      OP_ADD:  alu_of = 3'b001;
      OP_SUB:  alu_of = 3'b010;
      OP_AND:  alu_of = 3'b011;
      OP_OR:   alu_of = 3'b100;
      OP_MUL:  alu_of = 3'b101;
      default: alu_of = 3'b000;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    opc_n   = opc;
    fault_n = 1'b0;
    retire  = 1'b0;
    case (state)
      S_IDLE: if (Run) state_n = S_T0;
      S_T0: begin
        state_n = S_T1;
        wait_n  = '0;
      end
      S_T1: begin
        if (MemDone) begin
          state_n = S_T2;
          wait_n  = '0;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_n = S_IDLE;
          wait_n  = '0;
          fault_n = 1'b1;
        end else begin
          wait_n = wait_cnt + WAIT_W'(1);
        end
      end
      S_T2: begin
        state_n = S_T3;
        opc_n   = IR[OPC_MSB -: OPC_BITS];
      end
      S_T3: state_n = (alu_of(opc) != 3'b000) ? S_T4 : (Run ? S_T0 : S_IDLE);
      S_T4: state_n = S_T5;
      S_T5: begin
        if (opc == OP_MUL) begin
          state_n = S_T6;
        end else begin
          retire  = 1'b1;
          state_n = Run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        retire  = 1'b1;
        state_n = Run ? S_T0 : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Strobes are decoded from the state being entered so they register in step with it.
  always_comb begin
    ctl_n = '0;
    case (state_n)
      S_T0: begin
        ctl_n.pc_out = 1'b1;
        ctl_n.mar_in = 1'b1;
        ctl_n.inc_pc = 1'b1;
        ctl_n.z_in   = 1'b1;
      end
      S_T1: begin
        ctl_n.read   = 1'b1;
        ctl_n.mdr_in = 1'b1;
        if (state == S_T0) begin
          ctl_n.zlow_out = 1'b1;
          ctl_n.pc_in    = 1'b1;
        end
      end
      S_T2: begin
        ctl_n.mdr_out = 1'b1;
        ctl_n.ir_in   = 1'b1;
      end
      S_T3: begin
        if (alu_of(opc_n) != 3'b000) begin
          ctl_n.grb   = 1'b1;
          ctl_n.r_out = 1'b1;
          ctl_n.y_in  = 1'b1;
        end else begin
          ctl_n.illegal = 1'b1;
        end
      end
      S_T4: begin
        ctl_n.grc    = 1'b1;
        ctl_n.r_out  = 1'b1;
        ctl_n.z_in   = 1'b1;
        ctl_n.alu_op = alu_of(opc_n);
      end
      S_T5: begin
        ctl_n.zlow_out = 1'b1;
        if (opc_n == OP_MUL) begin
          ctl_n.lo_in = 1'b1;
        end else begin
          ctl_n.gra  = 1'b1;
          ctl_n.r_in = 1'b1;
        end
      end
      S_T6: begin
        ctl_n.zhigh_out = 1'b1;
        ctl_n.hi_in     = 1'b1;
      end
      default: ctl_n = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      opc      <= '0;
      ctl      <= '0;
      Fault    <= 1'b0;
      Retired  <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      opc      <= opc_n;
      ctl      <= ctl_n;
      Fault    <= fault_n;
      Retired  <= Retired + CNT_W'(retire);
    end
  end

  assign Step     = state;
  assign PCout    = ctl.pc_out;
  assign Zlowout  = ctl.zlow_out;
  assign Zhighout = ctl.zhigh_out;
  assign MDRout   = ctl.mdr_out;
  assign MARin    = ctl.mar_in;
  assign Zin      = ctl.z_in;
  assign PCin     = ctl.pc_in;
  assign MDRin    = ctl.mdr_in;
  assign IRin     = ctl.ir_in;
  assign Yin      = ctl.y_in;
  assign IncPC    = ctl.inc_pc;
  assign Read     = ctl.read;
  assign Gra      = ctl.gra;
  assign Grb      = ctl.grb;
  assign Grc      = ctl.grc;
  assign Rin      = ctl.r_in;
  assign Rout     = ctl.r_out;
  assign LOin     = ctl.lo_in;
  assign HIin     = ctl.hi_in;
  assign ALU_op   = ctl.alu_op;
  assign Illegal  = ctl.illegal;

endmodule

// File: tb/tb_control_step_sequencer.sv
// Randomized instruction streams checked cycle by cycle against an instruction-level expected-step model.
module tb_control_step_sequencer;

  localparam int TMO = 8;

  localparam int PCOUT = 18, ZLOW = 17, ZHIGH = 16, MDROUT = 15, MARIN = 14, ZIN = 13,
                 PCIN = 12, MDRIN = 11, IRIN = 10, YIN = 9, INCPC = 8, READ = 7,
                 GRA = 6, GRB = 5, GRC = 4, RIN = 3, ROUT = 2, LOIN = 1, HIIN = 0;

  logic        Clock = 1'b0;
  logic        Clear, Run, MemDone;
  logic [31:0] IR;
  logic PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic Gra, Grb, Grc, Rin, Rout, LOin, HIin, Illegal, Fault;
  logic [2:0] ALU_op, Step;
  logic [1:0] Retired;

  int checks = 0;
  int errors = 0;
  int model_ret = 0;
  bit idle = 1'b1;

  always #5 Clock = ~Clock;

  control_step_sequencer #(.OPC_MSB(31), .OPC_BITS(5), .MEM_TIMEOUT(TMO), .CNT_W(2)) dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .MemDone(MemDone), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .MARin(MARin),
    .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .LOin(LOin), .HIin(HIin),
    .ALU_op(ALU_op), .Step(Step), .Illegal(Illegal), .Fault(Fault), .Retired(Retired)
  );

  wire [18:0] strb = {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
                      IncPC, Read, Gra, Grb, Grc, Rin, Rout, LOin, HIin};

  function automatic logic [18:0] b(input int n);
    b = 19'(1) << n;
  endfunction

  function automatic int alu_ref(input logic [4:0] opc);
    case (opc)
      5'b00011: alu_ref = 1;
      5'b00100: alu_ref = 2;
      5'b00101: alu_ref = 3;
      5'b00110: alu_ref = 4;
      5'b01111: alu_ref = 5;
      default:  alu_ref = 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_row(input string tag, input int step, input logic [18:0] s,
                            input int alu, input bit ill, input bit flt);
    check({tag, "_step"}, 32'(Step), 32'(step));
    check({tag, "_strobes"}, 32'(strb), 32'(s));
    check({tag, "_alu"}, 32'(ALU_op), 32'(alu));
    check({tag, "_illegal"}, 32'(Illegal), 32'(ill));
    check({tag, "_fault"}, 32'(Fault), 32'(flt));
    check({tag, "_retired"}, 32'(Retired), 32'(model_ret % 4));
    check({tag, "_bus_excl"}, 32'($countones({PCout, Zlowout, Zhighout, MDRout, Rout}) <= 1), 32'd1);
  endtask

  task automatic do_clear();
    Clear = 1'b1; Run = 1'b1; MemDone = 1'b1;
    tick();
    Clear = 1'b0;
    model_ret = 0;
    expect_row("clr", 0, '0, 0, 0, 0);
  endtask

  // One instruction from its T0 cycle to completion; ended_idle reports whether it left the sequencer idle.
  task automatic run_instr(input logic [31:0] ir, input int lat, input bit run_end,
                           input int clear_step, output bit ended_idle);
    logic [4:0] opc;
    int  alu;
    bit  legal, mul;
    opc   = ir[31:27];
    alu   = alu_ref(opc);
    legal = (alu != 0);
    mul   = (opc == 5'b01111);
    ended_idle = 1'b1;
    IR = ir;
    expect_row("t0", 1, b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN), 0, 0, 0);
    if (clear_step == 1) begin do_clear(); return; end
    MemDone = 1'($urandom); Run = 1'($urandom);
    tick();
    for (int k = 0; k < TMO; k++) begin
      expect_row("t1", 2, (k == 0) ? (b(ZLOW) | b(PCIN) | b(READ) | b(MDRIN)) : (b(READ) | b(MDRIN)), 0, 0, 0);
      if (clear_step == 2 && k == 2) begin do_clear(); return; end
      MemDone = (k == lat); Run = 1'($urandom);
      tick();
      if (k == lat) break;
    end
    if (lat >= TMO) begin
      expect_row("tmo", 0, '0, 0, 0, 1);
      return;
    end
    expect_row("t2", 3, b(MDROUT) | b(IRIN), 0, 0, 0);
    if (clear_step == 3) begin do_clear(); return; end
    MemDone = 1'($urandom); Run = 1'($urandom);
    tick();
    expect_row("t3", 4, legal ? (b(GRB) | b(ROUT) | b(YIN)) : '0, 0, !legal, 0);
    if (clear_step == 4) begin do_clear(); return; end
    MemDone = 1'($urandom); Run = legal ? 1'($urandom) : run_end;
    tick();
    if (!legal) begin
      if (run_end) ended_idle = 1'b0;
      else expect_row("ill_idle", 0, '0, 0, 0, 0);
      return;
    end
    expect_row("t4", 5, b(GRC) | b(ROUT) | b(ZIN), alu, 0, 0);
    if (clear_step == 5) begin do_clear(); return; end
    MemDone = 1'($urandom); Run = 1'($urandom);
    tick();
    expect_row("t5", 6, mul ? (b(ZLOW) | b(LOIN)) : (b(ZLOW) | b(GRA) | b(RIN)), 0, 0, 0);
    if (clear_step == 6) begin do_clear(); return; end
    MemDone = 1'($urandom); Run = mul ? 1'($urandom) : run_end;
    tick();
    if (mul) begin
      expect_row("t6", 7, b(ZHIGH) | b(HIIN), 0, 0, 0);
      if (clear_step == 7) begin do_clear(); return; end
      MemDone = 1'($urandom); Run = run_end;
      tick();
    end
    model_ret++;
    if (run_end) ended_idle = 1'b0;
    else expect_row("done_idle", 0, '0, 0, 0, 0);
  endtask

  task automatic episode(input logic [31:0] ir, input int lat, input bit run_end, input int clear_step);
    if (idle) begin
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        Run = 1'b0; MemDone = 1'($urandom);
        tick();
        expect_row("idle", 0, '0, 0, 0, 0);
      end
      Run = 1'b1; MemDone = 1'($urandom);
      tick();
    end
    run_instr(ir, lat, run_end, clear_step, idle);
  endtask

  initial begin
    logic [4:0] opc;
    logic [4:0] legal_ops [5];
    legal_ops[0] = 5'b00011; legal_ops[1] = 5'b00100; legal_ops[2] = 5'b00101;
    legal_ops[3] = 5'b00110; legal_ops[4] = 5'b01111;

    Clear = 1'b1; Run = 1'b1; MemDone = 1'b1; IR = '0;
    tick();
    tick();
    Clear = 1'b0; Run = 1'b0;
    expect_row("rst", 0, '0, 0, 0, 0);
    tick();
    expect_row("rst_hold", 0, '0, 0, 0, 0);

    episode(32'h28918000, 0, 1'b1, 0);
    episode({5'b01111, 27'h1234567}, 2, 1'b1, 0);
    episode({5'b00011, 27'h0}, TMO, 1'b1, 0);
    episode({5'b00011, 27'h55}, TMO - 1, 1'b1, 0);
    episode({5'b11111, 27'h7}, 1, 1'b1, 0);
    episode({5'b00100, 27'h9}, 3, 1'b1, 0);
    episode({5'b00100, 27'h9}, 3, 1'b1, 5);
    episode({5'b00101, 27'h3}, TMO + 1, 1'b1, 2);
    for (int i = 0; i < 5; i++) episode({legal_ops[i], 27'($urandom)}, i, (i != 4), 0);
    episode({5'b00110, 27'h1}, 1, 1'b0, 0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) != 0) opc = legal_ops[$urandom_range(0, 4)];
      else opc = 5'($urandom);
      episode({opc, 27'($urandom)}, int'($urandom_range(0, TMO + 1)), 1'($urandom),
              ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 7)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_step_sequencer.md
CONTROL_STEP_SEQUENCER -- requirements
Module: control_step_sequencer

Interface
REQ-001 The block SHALL expose parameter OPC_MSB, default 31, meaning the IR bit index of the opcode MSB.
REQ-002 The block SHALL expose parameter OPC_BITS, default 5, meaning the opcode field width.
REQ-003 The block SHALL expose parameter MEM_TIMEOUT, default 8, meaning the maximum T1 wait cycles for MemDone.
REQ-004 The block SHALL expose parameter CNT_W, default 16, meaning the retired-instruction counter width.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 Port Clock  in  1  rising-edge clock for all state.
REQ-007 Port Clear  in  1  synchronous active-high reset.
REQ-008 Port Run  in  1  level; high permits fetch start from IDLE and back-to-back fetch after the last step.
REQ-009 Port MemDone  in  1  memory read complete; sampled only in T1.
REQ-010 Port IR  in  32  instruction register contents; decoded in T3 onward.
REQ-011 Ports PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read  out  1 each  datapath strobes.
REQ-012 Ports Gra, Grb, Grc, Rin, Rout, LOin, HIin  out  1 each  register-select and register-file strobes.
REQ-013 Port ALU_op  out  3  000 pass, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 MUL.
REQ-014 Port Step  out  3  current state: 0 IDLE, 1..7 = T0..T6.
REQ-015 Ports Illegal, Fault  out  1 each  one-cycle pulses.
REQ-016 Port Retired  out  CNT_W  count of completed instructions.

Function
REQ-017 Outputs SHALL be registered Moore decodes of state; all strobes SHALL be 0 in IDLE.
REQ-018 IDLE SHALL go to T0 on the first edge with Run=1.
REQ-019 T0 SHALL assert PCout, MARin, IncPC, Zin; next state T1.
REQ-020 T1 SHALL assert Zlowout, PCin, Read, MDRin; PCin and Zlowout SHALL be asserted only on the first T1 cycle; Read and MDRin SHALL hold for every T1 cycle.
REQ-021 T1 SHALL advance to T2 on the edge where MemDone=1; a wait counter SHALL increment per T1 cycle without MemDone.
REQ-022 If the wait counter reaches MEM_TIMEOUT with MemDone=0, the block SHALL pulse Fault and go to IDLE; MemDone=1 on that same edge SHALL take priority (advance to T2, no Fault).
REQ-023 T2 SHALL assert MDRout, IRin; next state T3.
REQ-024 T3 SHALL decode IR[OPC_MSB -: OPC_BITS]: 00011 ADD, 00100 SUB, 00101 AND, 00110 OR, 01111 MUL; any other value SHALL pulse Illegal, assert no strobes, and go to T0 if Run=1, else IDLE.
REQ-025 T3 (legal) SHALL assert Grb, Rout, Yin; next state T4.
REQ-026 T4 SHALL assert Grc, Rout, Zin, and ALU_op per opcode; ALU_op SHALL be 000 in all other states.
REQ-027 T5 for ADD/SUB/AND/OR SHALL assert Zlowout, Gra, Rin, and SHALL be the final step.
REQ-028 T5 for MUL SHALL assert Zlowout, LOin; T6 SHALL assert Zhighout, HIin and SHALL be the final step.
REQ-029 At the final step the block SHALL increment Retired (wrapping modulo 2^CNT_W) and go to T0 if Run=1, else IDLE.
REQ-030 Run deasserted mid-instruction SHALL NOT abort the instruction; it only selects IDLE at completion.
REQ-031 No two of PCout, Zlowout, Zhighout, MDRout, Rout SHALL be asserted in the same cycle.

Reset
REQ-032 Clear=1 on a rising edge SHALL force IDLE, Step=0, all strobes 0, ALU_op=000, Illegal=0, Fault=0, wait counter 0, Retired 0, regardless of state, including mid-T1 wait.
REQ-033 Clear SHALL take priority over Run and MemDone on the same edge.

Verification
REQ-034 Clear, Run=1, MemDone=1 in T1, IR=32'h28918000 -> Step 1,2,3,4,5,6; T4 ALU_op=011; T5 Gra+Rin; Retired=1; back to T0.
REQ-035 IR opcode 01111 (MUL) -> T5 LOin+Zlowout, T6 HIin+Zhighout, Step reaches 7, Retired increments once.
REQ-036 MemDone held 0 with MEM_TIMEOUT=8 -> Read high 8 cycles, Fault pulse, Step=0; MemDone=1 on 8th cycle -> T2, no Fault.
REQ-037 IR opcode 11111 -> Illegal pulse in T3, no Yin/Rout, Retired unchanged, next Step=1.
REQ-038 Clear asserted during T4 -> next cycle Step=0, all strobes 0, Retired=0.
REQ-039 Run dropped in T2 -> instruction completes through T5, then IDLE; CNT_W=2 and 5 retirements -> Retired=1.
